// File: rtl/memory_responder_if.sv
// memory_responder_if: request/response bus between an initiator and memory_responder.
//   Request (master -> slave): mem_addr_i, mem_wdata_i, mem_we_i, mem_req_i, mem_be_i.
//   Response (slave -> master): mem_rdata_o, mem_gnt_o, mem_rvalid_o, mem_error_o.
interface memory_responder_if;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_we_i;
  logic        mem_req_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_rdata_o;
  logic        mem_gnt_o;
  logic        mem_rvalid_o;
  logic        mem_error_o;

  modport master (
    output mem_addr_i, mem_wdata_i, mem_we_i, mem_req_i, mem_be_i,
    input  mem_rdata_o, mem_gnt_o, mem_rvalid_o, mem_error_o
  );

  modport slave (
    input  mem_addr_i, mem_wdata_i, mem_we_i, mem_req_i, mem_be_i,
    output mem_rdata_o, mem_gnt_o, mem_rvalid_o, mem_error_o
  );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: word-organised memory slave with programmable grant stall
// and response latency, one outstanding transaction at a time.
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous active-high reset (storage contents are not reset)
//   bus   - memory_responder_if.slave request/grant/response bus
// Parameters: DEPTH (words, power of two 4..4096), GNT_WAIT (0..15), RVALID_WAIT (0..15).
// Optional feature macro: MEMORY_RESPONDER_BOUNDS_CHECK_EN flags word indices
// >= DEPTH at grant, suppresses the write and returns mem_error_o=1.
module memory_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned GNT_WAIT    = 1,
  parameter int unsigned RVALID_WAIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  memory_responder_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STALL   = 3'd1;
  localparam logic [2:0] S_GRANT   = 3'd2;
  localparam logic [2:0] S_LATENCY = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] idx_q;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          oob;
  logic          accept;

  logic [31:0]   mem [DEPTH];

  assign word_idx = bus.mem_addr_i[31:2];
  assign mem_idx  = word_idx[AW-1:0];

`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
  // Any set bit above the storage index means the word lies beyond DEPTH.
  assign oob = |word_idx[29:AW];
`else
  assign oob = 1'b0;
`endif

  // The transaction is accepted in the single cycle the grant is visible.
  assign accept = (state_q == S_GRANT) && bus.mem_req_i;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_req_i) begin
          if (GNT_WAIT > 0) begin
            state_d = S_STALL;
            cnt_d   = 4'(GNT_WAIT - 1);
          end else begin
            state_d = S_GRANT;
          end
        end
      end
      S_STALL: begin
        if (!bus.mem_req_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_GRANT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GRANT: begin
        if (!bus.mem_req_i) begin
          state_d = S_IDLE;
        end else if (RVALID_WAIT > 0) begin
          state_d = S_LATENCY;
          cnt_d   = 4'(RVALID_WAIT - 1);
        end else begin
          state_d = S_RESPOND;
        end
      end
      S_LATENCY: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transaction fields and read capture at the grant edge; writes and
  // out-of-range accesses leave zero in the read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= bus.mem_we_i;
      be_q    <= bus.mem_be_i;
      idx_q   <= mem_idx;
      err_q   <= oob;
      rdata_q <= (bus.mem_we_i || oob) ? 32'd0 : mem[mem_idx];
    end
  end

  // Storage: byte-enabled write at the grant edge, deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && bus.mem_we_i && !oob) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be_i[b]) begin
          mem[mem_idx][8*b +: 8] <= bus.mem_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_gnt_o    = accept;
  assign bus.mem_rvalid_o = (state_q == S_RESPOND);
  assign bus.mem_rdata_o  = (state_q == S_RESPOND) ? rdata_q : 32'd0;

`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
  assign bus.mem_error_o  = (state_q == S_RESPOND) && err_q;
`else
  assign bus.mem_error_o  = 1'b0;
`endif

  // Latched fields kept for debug visibility plus address bits that carry no function.
  logic unused_bits;
  assign unused_bits = ^{bus.mem_addr_i[1:0], word_idx, we_q, be_q, idx_q, err_q};

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed bench for memory_responder. Instance u_a uses
// default parameters, u_b uses GNT_WAIT=0 / RVALID_WAIT=0.
module tb_memory_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] addr, wdata;
  logic        we, req_a, req_b;
  logic [3:0]  be;

  int vectors = 0;
  int miscompares = 0;

  memory_responder_if ifa ();
  memory_responder_if ifb ();

  assign ifa.mem_addr_i  = addr;
  assign ifa.mem_wdata_i = wdata;
  assign ifa.mem_we_i    = we;
  assign ifa.mem_be_i    = be;
  assign ifa.mem_req_i   = req_a;
  assign ifb.mem_addr_i  = addr;
  assign ifb.mem_wdata_i = wdata;
  assign ifb.mem_we_i    = we;
  assign ifb.mem_be_i    = be;
  assign ifb.mem_req_i   = req_b;

  memory_responder #(.DEPTH(256), .GNT_WAIT(1), .RVALID_WAIT(2)) u_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));

  memory_responder #(.DEPTH(256), .GNT_WAIT(0), .RVALID_WAIT(0)) u_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; latencies are counted in cycles from the request
  // cycle to grant and from grant to rvalid (20 means the bound expired).
  task automatic txn(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic [3:0] b,
                     output int gl, output int rl, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    addr = a; wdata = wd; we = w; be = b;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? ifb.mem_gnt_o : ifa.mem_gnt_o) && n < 20);
    gl = n;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    n = 1;
    while (!(sel ? ifb.mem_rvalid_o : ifa.mem_rvalid_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    rl = n;
    rd = sel ? ifb.mem_rdata_o : ifa.mem_rdata_o;
    er = sel ? ifb.mem_error_o : ifa.mem_error_o;
  endtask

  initial begin
    int gl, rl, seen;
    logic [31:0] rd;
    logic er;
    addr = 32'd0; wdata = 32'd0; we = 1'b0; be = 4'h0; req_a = 1'b0; req_b = 1'b0;

    // Outputs held at zero while in reset.
    @(negedge clk);
    chk("rst_gnt",    32'(ifa.mem_gnt_o),    32'd0);
    chk("rst_rvalid", 32'(ifa.mem_rvalid_o), 32'd0);
    chk("rst_rdata",  ifa.mem_rdata_o,       32'd0);
    chk("rst_error",  32'(ifa.mem_error_o),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic write then read, default timing.
    txn(0, 32'h40, 32'hDEADBEEF, 1'b1, 4'hF, gl, rl, rd, er);
    chk("wr40_gnt_lat", 32'(gl), 32'd2);
    chk("wr40_rv_lat",  32'(rl), 32'd3);
    chk("wr40_rdata",   rd,      32'd0);
    chk("wr40_err",     32'(er), 32'd0);
    txn(0, 32'h40, 32'h0, 1'b0, 4'hF, gl, rl, rd, er);
    chk("rd40_gnt_lat", 32'(gl), 32'd2);
    chk("rd40_rv_lat",  32'(rl), 32'd3);
    chk("rd40_rdata",   rd,      32'hDEADBEEF);
    chk("rd40_err",     32'(er), 32'd0);

    // Partial byte-enable write merges with existing bytes; read ignores be.
    txn(0, 32'h8, 32'h11223344, 1'b1, 4'hF, gl, rl, rd, er);
    txn(0, 32'h8, 32'hAABBCCDD, 1'b1, 4'b0101, gl, rl, rd, er);
    txn(0, 32'h8, 32'h0, 1'b0, 4'h0, gl, rl, rd, er);
    chk("rd8_merge", rd, 32'h11BB33DD);

    // Request dropped during STALL is aborted without side effects.
    txn(0, 32'hC, 32'h12345678, 1'b1, 4'hF, gl, rl, rd, er);
    @(negedge clk);
    addr = 32'hC; wdata = 32'hFFFFFFFF; we = 1'b1; be = 4'hF; req_a = 1'b1;
    @(negedge clk);
    chk("abort_stall_gnt", 32'(ifa.mem_gnt_o), 32'd0);
    req_a = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifa.mem_gnt_o || ifa.mem_rvalid_o) seen++;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    txn(0, 32'hC, 32'h0, 1'b0, 4'hF, gl, rl, rd, er);
    chk("abort_gnt_lat", 32'(gl), 32'd2);
    chk("abort_rdata",   rd,      32'h12345678);

    // Out-of-range word index: flagged with bounds check, aliases otherwise.
    txn(0, 32'h0, 32'h01020304, 1'b1, 4'hF, gl, rl, rd, er);
    txn(0, 32'h400, 32'h5A5A5A5A, 1'b1, 4'hF, gl, rl, rd, er);
`ifdef MEMORY_RESPONDER_BOUNDS_CHECK_EN
    chk("oob_wr_err", 32'(er), 32'd1);
    txn(0, 32'h0, 32'h0, 1'b0, 4'hF, gl, rl, rd, er);
    chk("oob_rd0", rd, 32'h01020304);
    txn(0, 32'h400, 32'h0, 1'b0, 4'hF, gl, rl, rd, er);
    chk("oob_rd_err",   32'(er), 32'd1);
    chk("oob_rd_rdata", rd,      32'd0);
`else
    chk("oob_wr_err", 32'(er), 32'd0);
    txn(0, 32'h0, 32'h0, 1'b0, 4'hF, gl, rl, rd, er);
    chk("oob_rd0", rd, 32'h5A5A5A5A);
`endif

    // Reset during LATENCY: committed write survives, response never issued.
    @(negedge clk);
    addr = 32'h10; wdata = 32'hCAFEF00D; we = 1'b1; be = 4'hF; req_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstlat_gnt", 32'(ifa.mem_gnt_o), 32'd1);
    @(negedge clk);
    req_a = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstlat_rvalid", 32'(ifa.mem_rvalid_o), 32'd0);
    chk("rstlat_gnt0",   32'(ifa.mem_gnt_o),    32'd0);
    chk("rstlat_rdata",  ifa.mem_rdata_o,       32'd0);
    chk("rstlat_error",  32'(ifa.mem_error_o),  32'd0);
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ifa.mem_rvalid_o) seen++;
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifa.mem_rvalid_o) seen++;
    end
    chk("rstlat_no_rvalid", 32'(seen), 32'd0);
    txn(0, 32'h10, 32'h0, 1'b0, 4'hF, gl, rl, rd, er);
    chk("rstlat_rd10", rd, 32'hCAFEF00D);

    // Zero-wait instance: minimum latencies and back-to-back spacing.
    txn(1, 32'h0, 32'h0A0A0A0A, 1'b1, 4'hF, gl, rl, rd, er);
    chk("b_wr_gnt_lat", 32'(gl), 32'd1);
    chk("b_wr_rv_lat",  32'(rl), 32'd1);
    txn(1, 32'h4, 32'h0B0B0B0B, 1'b1, 4'hF, gl, rl, rd, er);
    @(negedge clk);
    addr = 32'h0; we = 1'b0; be = 4'hF; req_b = 1'b1;
    @(negedge clk);
    chk("b2b_gnt1_t1", 32'(ifb.mem_gnt_o), 32'd1);
    @(negedge clk);
    chk("b2b_rv1_t2",  32'(ifb.mem_rvalid_o), 32'd1);
    chk("b2b_rd1",     ifb.mem_rdata_o,       32'h0A0A0A0A);
    chk("b2b_gnt_t2",  32'(ifb.mem_gnt_o),    32'd0);
    addr = 32'h4;
    @(negedge clk);
    chk("b2b_gnt_t3",  32'(ifb.mem_gnt_o),    32'd0);
    @(negedge clk);
    chk("b2b_gnt2_t4", 32'(ifb.mem_gnt_o),    32'd1);
    @(negedge clk);
    req_b = 1'b0;
    chk("b2b_rv2_t5",  32'(ifb.mem_rvalid_o), 32'd1);
    chk("b2b_rd2",     ifb.mem_rdata_o,       32'h0B0B0B0B);
    @(negedge clk);
    chk("b_idle_rdata", ifb.mem_rdata_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DEPTH, default 256, storage size in 32-bit words; power of two, 4..4096.
REQ-002 Parameter GNT_WAIT, default 1, extra stall cycles before grant; 0..15.
REQ-003 Parameter RVALID_WAIT, default 2, extra cycles between grant and response; 0..15.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-007 mem_wdata_i  input  32  write data.
REQ-008 mem_we_i  input  1  1 = write, 0 = read.
REQ-009 mem_req_i  input  1  request; initiator holds it and all request fields stable until grant.
REQ-010 mem_be_i  input  4  byte enables; bit n selects byte [8n+7:8n].
REQ-011 mem_rdata_o  output  32  read data; valid only with mem_rvalid_o.
REQ-012 mem_gnt_o  output  1  one-cycle grant pulse; request fields sampled in this cycle.
REQ-013 mem_rvalid_o  output  1  one-cycle response pulse.
REQ-014 mem_error_o  output  1  response error; valid only with mem_rvalid_o.

Function
REQ-015 States SHALL be IDLE, STALL, GRANT, LATENCY, RESPOND; a 4-bit down-counter SHALL time STALL and LATENCY.
REQ-016 IDLE, mem_req_i=1: next state STALL with counter=GNT_WAIT-1 if GNT_WAIT>0, else GRANT.
REQ-017 STALL: mem_req_i=0 -> IDLE (abort, no side effects); counter 0 -> GRANT; otherwise decrement.
REQ-018 mem_gnt_o SHALL equal (state==GRANT && mem_req_i); for request first seen at cycle t, grant occurs at cycle t+1+GNT_WAIT.
REQ-019 GRANT with mem_req_i=0 -> IDLE, no transaction.
REQ-020 GRANT with mem_req_i=1: latch we, be, word index; next state LATENCY with counter=RVALID_WAIT-1 if RVALID_WAIT>0, else RESPOND.
REQ-021 Write SHALL commit at the edge ending the grant cycle, only bytes with mem_be_i set; other bytes unchanged.
REQ-022 Read SHALL capture the addressed word at the edge ending the grant cycle into the read-data register; mem_be_i ignored for reads (full word returned).
REQ-023 LATENCY: decrement; counter 0 -> RESPOND; mem_req_i ignored.
REQ-024 RESPOND: mem_rvalid_o=1 for exactly this cycle, at grant cycle g+1+RVALID_WAIT; next state IDLE unconditionally.
REQ-025 mem_rdata_o SHALL be the captured word in RESPOND for reads, 0 for writes, and 0 in all other states.
REQ-026 One outstanding transaction; no grant between a grant and its response; minimum request-to-request period is 3+GNT_WAIT+RVALID_WAIT cycles.
REQ-027 Word index = mem_addr_i[31:2]; storage addressed by its low log2(DEPTH) bits.
REQ-028 Read of a word written in an earlier transaction SHALL return the written data.

Reset
REQ-029 On reset: state IDLE, counter 0, latched fields 0, mem_gnt_o=0, mem_rvalid_o=0, mem_error_o=0, mem_rdata_o=0, asynchronously.
REQ-030 Storage contents SHALL NOT be reset; undefined after power-up, preserved across reset.
REQ-031 Reset mid-transaction: a write already committed (past grant) stays committed; the pending response SHALL never be issued.

Configuration
REQ-032 Macro MEMORY_RESPONDER_BOUNDS_CHECK_EN defined: word index >= DEPTH SHALL be flagged at grant; its response has mem_error_o=1, mem_rdata_o=0, and any write is suppressed.
REQ-033 Macro undefined: out-of-range indices alias by truncation per REQ-027; mem_error_o SHALL be constant 0.

Verification
REQ-034 Defaults; write 0xDEADBEEF, be=4'hF, addr 0x40; read addr 0x40 -> gnt 2 cycles after req, rvalid 3 cycles after gnt, rdata 0xDEADBEEF, error 0.
REQ-035 Write 0x11223344 be=4'hF then 0xAABBCCDD be=4'b0101 to addr 0x8; read -> rdata 0x11BB33DD.
REQ-036 GNT_WAIT=0, RVALID_WAIT=0; back-to-back reads addr 0x0, 0x4 -> gnt at t+1, rvalid at t+2, second gnt no earlier than t+4.
REQ-037 Drop mem_req_i during STALL -> no gnt, no rvalid, storage unchanged, next request served normally.
REQ-038 DEPTH=256, macro defined: write 0x5A5A5A5A to addr 0x400 -> rvalid with error=1; read addr 0x0 unchanged. Macro undefined: same write -> error=0, read addr 0x0 returns 0x5A5A5A5A.
REQ-039 Assert reset during LATENCY of a write to addr 0x10 -> no rvalid, all outputs 0; after release, read addr 0x10 returns the written data.
